pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 50 +++++
 tb/tb_pipe_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller producing per-stage stall vector, exception flush and stall statistics.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic        stall_timeout
);
  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;
  state_t state, state_n;
  logic [7:0] ep;
  logic any_req, exc, stalling;
  always_comb begin
    any_req = stallreq_from_if | stallreq_from_id | stallreq_from_ex | stallreq_from_mem;
    exc = |excepttype_i;
    stall = (rst || state == FLUSH) ? 6'b000000 :
            stallreq_from_mem ? 6'b011111 :
            stallreq_from_ex  ? 6'b001111 :
            (stallreq_from_id || stallreq_from_if) ? 6'b000111 : 6'b000000;
    stalling = |stall;
    state_n = state == FLUSH ? IDLE : exc ? FLUSH : any_req ? STALL : IDLE;
  end
  assign flush = state == FLUSH;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      new_pc        <= 32'h0;
      stall_cnt     <= 32'h0;
      ep            <= 8'h0;
      stall_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      stall_cnt <= stall_cnt + {31'h0, stalling};
      if (state_n == FLUSH)
        new_pc <= (excepttype_i == 32'h0000000e) ? cp0_epc_i : 32'h00000020;
      // episode length only grows while the controller stays in STALL
      ep <= (state == STALL && state_n == STALL && stalling) ? ep + {7'h0, ep != 8'hff} : 8'h0;
      if (ep == 8'hff && stalling)
        stall_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a history-based behavioural model.
module tb_pipe_ctrl;
  logic clk = 0, rst = 1;
  logic rq_if = 0, rq_id = 0, rq_ex = 0, rq_mem = 0;
  logic [31:0] exc = 0, epc = 0;
  logic [5:0] stall;
  logic flush, stall_timeout;
  logic [31:0] new_pc, stall_cnt;
  int total = 0, bad = 0;
  bit started = 0;
  // model: flush/stall-state derived from the previous cycle's inputs
  bit m_flush = 0, m_in_stall = 0, m_to = 0;
  int m_ep = 0;
  logic [31:0] m_pc = 0, m_cnt = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(rq_if), .stallreq_from_id(rq_id),
    .stallreq_from_ex(rq_ex), .stallreq_from_mem(rq_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_stall();
    if (rst || m_flush) return 6'd0;
    if (rq_mem) return 6'b011111;
    if (rq_ex) return 6'b001111;
    if (rq_id || rq_if) return 6'b000111;
    return 6'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [5:0] s;
    bit nf, ns;
    s = exp_stall();
    if (rst) begin
      started = 1;
      m_flush = 0; m_in_stall = 0; m_to = 0; m_ep = 0; m_pc = 0; m_cnt = 0;
    end else begin
      nf = !m_flush && exc != 0;
      ns = !m_flush && exc == 0 && (rq_if || rq_id || rq_ex || rq_mem);
      if (nf) m_pc = (exc == 32'h0000000e) ? epc : 32'h00000020;
      if (s != 0) m_cnt = m_cnt + 1;
      if (m_ep == 255 && s != 0) m_to = 1;
      m_ep = (m_in_stall && ns) ? (m_ep == 255 ? 255 : m_ep + 1) : 0;
      m_flush = nf;
      m_in_stall = ns;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("stall", {26'd0, stall}, {26'd0, exp_stall()});
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
      chk("new_pc", new_pc, m_pc);
      chk("stall_cnt", stall_cnt, m_cnt);
      chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
    end
  end

  task automatic cyc(input logic [3:0] req, input logic [31:0] e, input logic [31:0] pc, input logic r);
    {rq_mem, rq_ex, rq_id, rq_if} = req;
    exc = e; epc = pc; rst = r;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    adv();
    cyc(4'b1000, 0, 0, 1); chk("pin_rst_stall", {26'd0, stall}, 32'd0); adv();
    cyc(4'b0000, 0, 0, 1); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0010, 0, 0, 0); chk("pin_id_stall", {26'd0, stall}, 32'h07); adv();
    end
    cyc(4'b0000, 0, 0, 0); chk("pin_id_after", {26'd0, stall}, 32'd0);
    chk("pin_id_cnt", stall_cnt, 32'd3); adv();
    cyc(4'b1010, 0, 0, 0); chk("pin_mem_id", {26'd0, stall}, 32'h1f); adv();
    cyc(4'b0000, 0, 0, 0); adv();
    cyc(4'b0000, 32'h8, 0, 0); adv();
    cyc(4'b0010, 0, 0, 0); chk("pin_exc_flush", {31'd0, flush}, 32'd1);
    chk("pin_exc_pc", new_pc, 32'h20); chk("pin_exc_stall", {26'd0, stall}, 32'd0); adv();
    cyc(4'b0000, 0, 0, 0); chk("pin_exc_after", {31'd0, flush}, 32'd0); adv();
    cyc(4'b0000, 0, 0, 0); adv();
    cyc(4'b0100, 32'he, 32'h00400104, 0); chk("pin_eret_stall", {26'd0, stall}, 32'h0f); adv();
    cyc(4'b0000, 0, 0, 0); chk("pin_eret_flush", {31'd0, flush}, 32'd1);
    chk("pin_eret_pc", new_pc, 32'h00400104); chk("pin_eret_stall0", {26'd0, stall}, 32'd0); adv();
    cyc(4'b0000, 32'h8, 0, 0); adv();
    cyc(4'b0000, 0, 0, 1); chk("pin_rstfl_flush", {31'd0, flush}, 32'd1); adv();
    cyc(4'b0000, 0, 0, 0); chk("pin_rstfl_after", {31'd0, flush}, 32'd0);
    chk("pin_rstfl_cnt", stall_cnt, 32'd0); adv();
    for (int i = 0; i < 300; i++) begin
      cyc(4'b0100, 0, 0, 0);
      if (i == 200) chk("pin_to_early", {31'd0, stall_timeout}, 32'd0);
      adv();
    end
    cyc(4'b0000, 0, 0, 0); chk("pin_to_cnt", stall_cnt, 32'd300);
    chk("pin_to_set", {31'd0, stall_timeout}, 32'd1); adv();
    cyc(4'b0000, 0, 0, 0); chk("pin_to_sticky", {31'd0, stall_timeout}, 32'd1); adv();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] e;
      e = ($urandom_range(0, 15) == 0) ? (($urandom_range(0, 1) == 0) ? 32'he : $urandom_range(1, 255)) : 32'd0;
      cyc(4'($urandom_range(0, 15) & $urandom_range(0, 15)), e, $urandom(), $urandom_range(0, 99) == 0);
      adv();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
